// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, arbitrates the instruction memory
// between the program loader and instruction fetch, and drives IF/ID.
//
// state | meaning
// IDLE  | waiting for loader ownership request or start; IF/ID holds nop
// LOAD  | loader owns memory; aligned in-range writes pass through
// RUN   | fetching; pc advances, stalls, or redirects
// FAULT | pc went misaligned or out of range; frozen until reset
module imem_fetch_ctrl #(
   parameter int          IMEM_BYTES = 128,
   parameter logic [31:0] RESET_PC   = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ld_req,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        ld_err,
   output logic        imem_we,
   output logic [31:0] imem_waddr,
   output logic [31:0] imem_wdata,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic        running,
   output logic        fault
);

   localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        ld_ok;
   logic        pc_ok;

   // Address legality for loader writes and for the current fetch address
   always_comb begin
      ld_ok = (ld_addr[1:0] == 2'b00) && (ld_addr <= LAST_WORD);
      pc_ok = (pc[1:0] == 2'b00) && (pc <= LAST_WORD);
   end

   // Memory port: loader writes only while it owns memory, fetch reads at pc
   always_comb begin
      imem_we    = (state == LOAD) && ld_valid && ld_ok;
      imem_waddr = ld_addr;
      imem_wdata = ld_data;
      imem_addr  = pc;
   end

   // Controller FSM with pc, IF/ID register and status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         ifid_instr <= 32'd0;
         ifid_pc4   <= 32'd0;
         ifid_valid <= 1'b0;
         ld_err     <= 1'b0;
         running    <= 1'b0;
         fault      <= 1'b0;
      end else begin
         ld_err <= 1'b0;
         case (state)
            IDLE: begin
               ifid_instr <= 32'd0;
               ifid_pc4   <= 32'd0;
               ifid_valid <= 1'b0;
               if (ld_req) begin
                  state <= LOAD;
               end else if (start) begin
                  state   <= RUN;
                  running <= 1'b1;
                  pc      <= RESET_PC;
               end
            end
            LOAD: begin
               ld_err <= ld_valid && !ld_ok;
               if (!ld_req) state <= IDLE;
            end
            RUN: begin
               // A bad pc is caught before anything is latched, even under stall
               if (!pc_ok) begin
                  state      <= FAULT;
                  running    <= 1'b0;
                  fault      <= 1'b1;
                  ifid_instr <= 32'd0;
                  ifid_valid <= 1'b0;
               end else if (stall) begin
                  pc <= pc;
               end else if (jump) begin
                  pc         <= jump_target;
                  ifid_instr <= 32'd0;
                  ifid_valid <= 1'b0;
               end else if (branch_taken) begin
                  pc         <= branch_target;
                  ifid_instr <= 32'd0;
                  ifid_valid <= 1'b0;
               end else begin
                  ifid_instr <= imem_rdata;
                  ifid_pc4   <= pc + 32'd4;
                  ifid_valid <= 1'b1;
                  pc         <= pc + 32'd4;
               end
            end
            FAULT: begin
               fault      <= 1'b1;
               running    <= 1'b0;
               ifid_instr <= 32'd0;
               ifid_valid <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a byte-wide big-endian memory.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, ld_req, ld_valid;
   logic [31:0] ld_addr, ld_data;
   logic        ld_err, imem_we;
   logic [31:0] imem_waddr, imem_wdata, imem_addr, imem_rdata;
   logic        stall, branch_taken, jump;
   logic [31:0] branch_target, jump_target;
   logic [31:0] ifid_instr, ifid_pc4;
   logic        ifid_valid, running, fault;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [0:127];

   imem_fetch_ctrl #(.IMEM_BYTES(128), .RESET_PC(32'd0)) dut (
      .clk(clk), .reset(reset), .start(start),
      .ld_req(ld_req), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_err(ld_err), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
      .running(running), .fault(fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_we && imem_waddr < 32'd125) begin
         mem[imem_waddr[6:0]]         <= imem_wdata[31:24];
         mem[imem_waddr[6:0] + 7'd1]  <= imem_wdata[23:16];
         mem[imem_waddr[6:0] + 7'd2]  <= imem_wdata[15:8];
         mem[imem_waddr[6:0] + 7'd3]  <= imem_wdata[7:0];
      end
   end

   always_comb begin
      imem_rdata = 32'hDEAD_BEEF;
      if (imem_addr < 32'd125)
         imem_rdata = {mem[imem_addr[6:0]], mem[imem_addr[6:0] + 7'd1],
                       mem[imem_addr[6:0] + 7'd2], mem[imem_addr[6:0] + 7'd3]};
   end

   function automatic logic [31:0] prog_word(input logic [31:0] a);
      if (a == 32'd0) return 32'h0001_1020;
      if (a == 32'd4) return 32'h0002_1820;
      return 32'hA500_0000 | a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; ld_req = 1'b0; ld_valid = 1'b0;
      ld_addr = 32'd0; ld_data = 32'd0; stall = 1'b0;
      branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0; jump_target = 32'd0;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      step(); step();
      chk("rst_running", {31'd0, running}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
      chk("rst_pc", imem_addr, 32'd0);
      chk("rst_ld_err", {31'd0, ld_err}, 32'd0);
      chk("rst_instr", ifid_instr, 32'd0);

      // Load the whole memory, boundary word at 124 included
      reset = 1'b1;
      ld_req = 1'b1;
      step();
      for (int a = 0; a <= 124; a += 4) begin
         ld_valid = 1'b1;
         ld_addr  = 32'(a);
         ld_data  = prog_word(32'(a));
         #1;
         if (a == 0 || a == 124) chk("ld_we_ok", {31'd0, imem_we}, 32'd1);
         step();
         if (a == 0) chk("ld_no_err", {31'd0, ld_err}, 32'd0);
      end

      // Loader errors: misaligned and out of range
      ld_addr = 32'd6; ld_data = 32'h1111_1111;
      #1 chk("ld_mis_we", {31'd0, imem_we}, 32'd0);
      step();
      chk("ld_mis_err", {31'd0, ld_err}, 32'd1);
      ld_addr = 32'd128;
      #1 chk("ld_oor_we", {31'd0, imem_we}, 32'd0);
      step();
      chk("ld_oor_err", {31'd0, ld_err}, 32'd1);
      ld_valid = 1'b0;
      step();
      chk("ld_err_pulse", {31'd0, ld_err}, 32'd0);

      // Back to IDLE, then start
      ld_req = 1'b0;
      start  = 1'b1;
      step();
      chk("load_exit_idle", {31'd0, running}, 32'd0);
      step();
      start = 1'b0;
      chk("run_entered", {31'd0, running}, 32'd1);
      chk("run_pc0", imem_addr, 32'd0);
      step();
      chk("f0_instr", ifid_instr, 32'h0001_1020);
      chk("f0_pc4", ifid_pc4, 32'd4);
      chk("f0_valid", {31'd0, ifid_valid}, 32'd1);
      step();
      chk("f1_instr", ifid_instr, 32'h0002_1820);
      chk("f1_pc4", ifid_pc4, 32'd8);
      chk("f1_pc", imem_addr, 32'd8);

      // Two-cycle stall at pc=8
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("stall_pc", imem_addr, 32'd8);
         chk("stall_instr", ifid_instr, 32'h0002_1820);
         chk("stall_pc4", ifid_pc4, 32'd8);
      end
      stall = 1'b0;
      step();
      chk("resume_instr", ifid_instr, prog_word(32'd8));
      chk("resume_pc", imem_addr, 32'd12);
      step();
      chk("pc16", imem_addr, 32'd16);

      // Jump at pc=16 to 40
      jump = 1'b1; jump_target = 32'd40;
      step();
      jump = 1'b0;
      chk("jmp_pc", imem_addr, 32'd40);
      chk("jmp_bubble", {31'd0, ifid_valid}, 32'd0);
      chk("jmp_nop", ifid_instr, 32'd0);
      step();
      chk("jmp_instr", ifid_instr, prog_word(32'd40));
      chk("jmp_pc4", ifid_pc4, 32'd44);
      chk("jmp_valid", {31'd0, ifid_valid}, 32'd1);

      // Jump wins over branch
      jump = 1'b1; jump_target = 32'd60;
      branch_taken = 1'b1; branch_target = 32'd80;
      step();
      jump = 1'b0; branch_taken = 1'b0;
      chk("prio_pc", imem_addr, 32'd60);
      chk("prio_bubble", {31'd0, ifid_valid}, 32'd0);
      step();
      chk("prio_instr", ifid_instr, prog_word(32'd60));

      // Stall + branch: held, then branch re-presented
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd100;
      step();
      chk("sb_pc", imem_addr, 32'd64);
      chk("sb_valid", {31'd0, ifid_valid}, 32'd1);
      chk("sb_instr", ifid_instr, prog_word(32'd60));
      stall = 1'b0;
      step();
      branch_taken = 1'b0;
      chk("br_pc", imem_addr, 32'd100);
      chk("br_bubble", {31'd0, ifid_valid}, 32'd0);
      step();
      chk("br_instr", ifid_instr, prog_word(32'd100));
      chk("br_next_pc", imem_addr, 32'd104);

      // Bad branch target: fault when it becomes pc
      branch_taken = 1'b1; branch_target = 32'd126;
      step();
      branch_taken = 1'b0;
      chk("bad_tgt_pc", imem_addr, 32'd126);
      chk("bad_tgt_nofault", {31'd0, fault}, 32'd0);
      step();
      chk("fault_set", {31'd0, fault}, 32'd1);
      chk("fault_valid", {31'd0, ifid_valid}, 32'd0);
      chk("fault_running", {31'd0, running}, 32'd0);
      ld_req = 1'b1; ld_valid = 1'b1; ld_addr = 32'd0; start = 1'b1;
      step();
      chk("fault_sticky", {31'd0, fault}, 32'd1);
      chk("fault_pc_frozen", imem_addr, 32'd126);
      chk("fault_no_we", {31'd0, imem_we}, 32'd0);
      ld_req = 1'b0; ld_valid = 1'b0; start = 1'b0;

      // Reset clears fault, then mid-RUN async reset
      reset = 1'b0;
      #1 chk("reset_clr_fault", {31'd0, fault}, 32'd0);
      step();
      reset = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      chk("rerun_pc", imem_addr, 32'd12);
      #2 reset = 1'b0;
      #1;
      chk("midrun_pc", imem_addr, 32'd0);
      chk("midrun_running", {31'd0, running}, 32'd0);
      chk("midrun_valid", {31'd0, ifid_valid}, 32'd0);
      reset = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
